multicycle_main_controller: RTL and testbench
=============================================

// Module: multicycle_main_controller
// PURPOSE
//  Main sequencing FSM for the multicycle RV32I core. Decodes opcode, steps datapath through fetch/decode/execute/mem/writeback.
//  Drives mux selects and write enables; emits the 2-bit ALUOp consumed by the ALU controller (00 add, 01 sub/branch, 10 R-type, 11 I-type).
//  Sits beside the ALU controller in the control unit; datapath regs (PC, IR, OldPC, ALUOut, Data) live outside.
// PARAMETERS
//  ILLEGAL_HALT  0  1: unknown opcode -> HALT until rst; 0: unknown opcode -> back to FETCH (instruction dropped)
// PORTS
//  clk         in   1  clock, all state changes on rising edge
//  rst         in   1  synchronous, active-high reset
//  opcode      in   7  IR[6:0]
//  func3       in   3  IR[14:12]; func3[0] selects beq(0)/bne(1)
//  zero        in   1  ALU zero flag (combinational, same cycle)
//  mem_ready   in   1  unified memory done strobe for current access
//  PCWrite     out  1  PC load = PCUpdate | (Branch & (zero ^ func3[0]))
//  AdrSrc      out  1  mem addr: 0 PC, 1 ALUOut
//  MemWrite    out  1  data memory write enable
//  IRWrite     out  1  IR + OldPC load
//  RegWrite    out  1  register file write enable
//  ResultSrc   out  2  00 ALUOut, 01 Data, 10 ALU result direct
//  ALUSrcA     out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
//  ALUSrcB     out  2  00 rs2, 01 imm, 10 const 4
//  ALUOp       out  2  to ALU controller
//  illegal     out  1  one-cycle pulse in DECODE on unsupported opcode
//  halted      out  1  high while in HALT
// BEHAVIOUR
//  rst=1: state<=FETCH next edge; while rst high all enables (PCWrite,MemWrite,IRWrite,RegWrite,illegal) forced 0,
//   selects 0, halted 0. Reset mid-instruction abandons it; no partial writes after rst sampled.
//  Outputs decoded from state (Moore) except PCWrite (zero, mem_ready) and FETCH enables (mem_ready). Unlisted outputs = 0.
//  FETCH   : AdrSrc0 A=00 B=10 ALUOp00 Res=10; IRWrite=PCUpdate=mem_ready. Stay until mem_ready, then DECODE.
//  DECODE  : A=01 B=01 ALUOp00 (branch/jal target -> ALUOut). Next by opcode:
//            0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 0110111 LUI,
//            else illegal=1 and FETCH (or HALT if ILLEGAL_HALT).
//  MEMADR  : A=10 B=01 ALUOp00 -> MEMREAD if opcode[5]=0 else MEMWRITE
//  MEMREAD : AdrSrc1 Res=00; hold until mem_ready -> MEMWB
//  MEMWB   : Res=01 RegWrite=1 -> FETCH
//  MEMWRITE: AdrSrc1 Res=00 MemWrite=1 (held until mem_ready) -> FETCH on mem_ready
//  EXECR   : A=10 B=00 ALUOp10 -> ALUWB     EXECI: A=10 B=01 ALUOp11 -> ALUWB
//  ALUWB   : Res=00 RegWrite=1 -> FETCH
//  BRANCH  : A=10 B=00 ALUOp01 Res=00 Branch=1 -> FETCH
//  JAL     : A=01 B=10 ALUOp00 Res=00 PCUpdate=1 -> ALUWB (rd<=OldPC+4)
//  LUI     : A=11 B=01 ALUOp00 -> ALUWB
//  HALT    : all enables 0, halted=1; exit only via rst
//  Latency (mem_ready=1 each access): lw 5, sw/R/I/jal/lui 4, branch 3 cycles. Each wait cycle adds 1.
//  mem_ready outside FETCH/MEMREAD/MEMWRITE ignored. Opcode sampled only in DECODE/MEMADR (IR stable).
//  State reg 4 bits; unreachable encodings -> FETCH.
// STRUCTURE
//  Shared package riscv_ctrl_pkg: opcode constants, ALUOp codes (shared with ALU controller), mux select encodings,
//   state enum. Optional sub-module: branch_pcwrite_logic (PCUpdate/Branch/zero/func3 -> PCWrite). Otherwise flat.
// TESTING
//  rst high 2 cycles, release -> state FETCH, enables 0 during rst; first post-reset cycle IRWrite=mem_ready.
//  lw (0000011), mem_ready=1 always -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite only in 5th, ResultSrc=01.
//  sw with mem_ready low 3 cycles in MEMWRITE -> MemWrite held 4 cycles, RegWrite never 1, then FETCH.
//  beq zero=1 -> PCWrite=1 in BRANCH; bne (func3=001) zero=1 -> PCWrite=0; ALUOp=01 both.
//  R add/I addi -> ALUOp 10 in EXECR / 11 in EXECI; jal -> PCWrite in JAL, RegWrite in ALUWB.
//  opcode 1111111 -> illegal pulse 1 cycle; ILLEGAL_HALT=1 -> halted=1 until rst; rst asserted in MEMREAD -> FETCH, no RegWrite.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared opcode, ALUOp, mux-select and state encodings for the multicycle control unit
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALUOp codes, also decoded by the ALU controller
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_HALT     = 4'd12
  } state_e;

endpackage

// File: rtl/branch_pcwrite_logic.sv
// rtl/branch_pcwrite_logic.sv - PC load enable from unconditional update or taken beq/bne
module branch_pcwrite_logic (
  input  logic pc_update_i,
  input  logic branch_i,
  input  logic zero_i,
  input  logic func3_0_i,
  output logic pc_write_o
);

  // func3[0]=1 (bne) inverts the sense of the zero flag
  assign pc_write_o = pc_update_i | (branch_i & (zero_i ^ func3_0_i));

endmodule

// File: rtl/multicycle_main_controller.sv
// rtl/multicycle_main_controller.sv - main sequencing FSM of the multicycle RV32I core
module multicycle_main_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic       halted
);

  state_e state_q, state_d;
  logic   pc_update, branch;
  logic   unused_func3;

  assign unused_func3 = ^func3[2:1];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOp     = ALUOP_ADD;
    illegal   = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = mem_ready;
        pc_update = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default: begin
            illegal = 1'b1;
            state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_RTYPE;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ITYPE;
        state_d = S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        // PC takes the DECODE-computed target from ALUOut; ALU forms OldPC+4 for rd
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = SRCA_ZERO;
        ALUSrcB = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase

    if (rst) begin
      pc_update = 1'b0;
      branch    = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      illegal   = 1'b0;
      halted    = 1'b0;
    end
  end

  branch_pcwrite_logic u_pcwrite (
    .pc_update_i (pc_update),
    .branch_i    (branch),
    .zero_i      (zero),
    .func3_0_i   (func3[0]),
    .pc_write_o  (PCWrite)
  );

endmodule

// File: tb/tb_multicycle_main_controller.sv
// tb/tb_multicycle_main_controller.sv - cycle-by-cycle vector bench for the main controller FSM
module tb_multicycle_main_controller;

  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;

  logic       h_rst, h_zero, h_mem_ready;
  logic [6:0] h_opcode;
  logic [2:0] h_func3;
  logic       h_PCWrite, h_AdrSrc, h_MemWrite, h_IRWrite, h_RegWrite, h_illegal, h_halted;
  logic [1:0] h_ResultSrc, h_ALUSrcA, h_ALUSrcB, h_ALUOp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_main_controller #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .illegal(illegal), .halted(halted)
  );

  multicycle_main_controller #(.ILLEGAL_HALT(1'b1)) dut_h (
    .clk(clk), .rst(h_rst), .opcode(h_opcode), .func3(h_func3), .zero(h_zero), .mem_ready(h_mem_ready),
    .PCWrite(h_PCWrite), .AdrSrc(h_AdrSrc), .MemWrite(h_MemWrite), .IRWrite(h_IRWrite), .RegWrite(h_RegWrite),
    .ResultSrc(h_ResultSrc), .ALUSrcA(h_ALUSrcA), .ALUSrcB(h_ALUSrcB), .ALUOp(h_ALUOp),
    .illegal(h_illegal), .halted(h_halted)
  );

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,illegal,halted}
  wire [14:0] act   = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                       ALUSrcA, ALUSrcB, ALUOp, illegal, halted};
  wire [14:0] act_h = {h_PCWrite, h_AdrSrc, h_MemWrite, h_IRWrite, h_RegWrite, h_ResultSrc,
                       h_ALUSrcA, h_ALUSrcB, h_ALUOp, h_illegal, h_halted};

  function automatic logic [14:0] ev(input logic pcw, adr, mw, irw, rw,
                                     input logic [1:0] res, a, b, op, input logic ill, hlt);
    return {pcw, adr, mw, irw, rw, res, a, b, op, ill, hlt};
  endfunction

  function automatic logic [14:0] x_fetch(input logic mr);
    return ev(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
  endfunction
  function automatic logic [14:0] x_decode(input logic ill);
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, ill, 0);
  endfunction
  function automatic logic [14:0] x_branch(input logic pcw);
    return ev(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 0);
  endfunction
  localparam logic [14:0] X_ZERO     = 15'd0;
  localparam logic [14:0] X_MEMADR   = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] X_MEMREAD  = {5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] X_MEMWB    = {5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] X_MEMWRITE = {5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] X_EXECR    = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
  localparam logic [14:0] X_EXECI    = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
  localparam logic [14:0] X_ALUWB    = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [14:0] X_JAL      = {5'b10000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
  localparam logic [14:0] X_LUI      = {5'b00000, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00};
  localparam logic [14:0] X_HALT     = 15'd1;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111, BADOP = 7'b1111111;

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        mr;
    logic [14:0] exp;
  } vec_t;

  vec_t tv[$];

  task automatic add(input string name, input logic r, input logic [6:0] op, input logic [2:0] f3,
                     input logic z, input logic mr, input logic [14:0] exp);
    vec_t v;
    v.name = name; v.rst = r; v.op = op; v.f3 = f3; v.z = z; v.mr = mr; v.exp = exp;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [14:0] a, input logic [14:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b required %b", name, a, e);
    end
  endtask

  task automatic step_h(input logic r, input logic [6:0] op, input logic mr, input logic [14:0] e,
                        input string name);
    @(posedge clk); #1;
    h_rst = r; h_opcode = op; h_mem_ready = mr;
    @(negedge clk);
    chk(name, act_h, e);
  endtask

  initial begin
    rst = 1'b1; opcode = LW; func3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
    h_rst = 1'b1; h_opcode = LW; h_func3 = 3'd0; h_zero = 1'b0; h_mem_ready = 1'b1;

    add("rst0", 1, LW, 0, 0, 1, X_ZERO);
    add("rst1", 1, LW, 0, 0, 1, X_ZERO);
    add("fetch_wait", 0, LW, 0, 0, 0, x_fetch(0));
    add("lw_fetch", 0, LW, 0, 0, 1, x_fetch(1));
    add("lw_decode", 0, LW, 0, 0, 1, x_decode(0));
    add("lw_memadr", 0, LW, 0, 0, 1, X_MEMADR);
    add("lw_memread", 0, LW, 0, 0, 1, X_MEMREAD);
    add("lw_memwb", 0, LW, 0, 0, 1, X_MEMWB);
    add("sw_fetch", 0, SW, 0, 0, 1, x_fetch(1));
    add("sw_decode", 0, SW, 0, 0, 1, x_decode(0));
    add("sw_memadr", 0, SW, 0, 0, 1, X_MEMADR);
    add("sw_wait1", 0, SW, 0, 0, 0, X_MEMWRITE);
    add("sw_wait2", 0, SW, 0, 0, 0, X_MEMWRITE);
    add("sw_wait3", 0, SW, 0, 0, 0, X_MEMWRITE);
    add("sw_done", 0, SW, 0, 0, 1, X_MEMWRITE);
    add("beq_fetch", 0, BR, 0, 1, 1, x_fetch(1));
    add("beq_decode", 0, BR, 0, 1, 1, x_decode(0));
    add("beq_taken", 0, BR, 0, 1, 1, x_branch(1));
    add("bne_fetch", 0, BR, 1, 1, 1, x_fetch(1));
    add("bne_decode", 0, BR, 1, 1, 1, x_decode(0));
    add("bne_nottaken", 0, BR, 1, 1, 1, x_branch(0));
    add("r_fetch", 0, RT, 0, 0, 1, x_fetch(1));
    add("r_decode", 0, RT, 0, 0, 1, x_decode(0));
    add("r_execr", 0, RT, 0, 0, 1, X_EXECR);
    add("r_aluwb", 0, RT, 0, 0, 1, X_ALUWB);
    add("i_fetch", 0, IT, 0, 0, 1, x_fetch(1));
    add("i_decode", 0, IT, 0, 0, 1, x_decode(0));
    add("i_execi", 0, IT, 0, 0, 1, X_EXECI);
    add("i_aluwb", 0, IT, 0, 0, 1, X_ALUWB);
    add("jal_fetch", 0, JL, 0, 0, 1, x_fetch(1));
    add("jal_decode", 0, JL, 0, 0, 1, x_decode(0));
    add("jal_jal", 0, JL, 0, 0, 1, X_JAL);
    add("jal_aluwb", 0, JL, 0, 0, 1, X_ALUWB);
    add("lui_fetch", 0, LU, 0, 0, 1, x_fetch(1));
    add("lui_decode", 0, LU, 0, 0, 1, x_decode(0));
    add("lui_lui", 0, LU, 0, 0, 1, X_LUI);
    add("lui_aluwb", 0, LU, 0, 0, 1, X_ALUWB);
    add("bad_fetch", 0, BADOP, 0, 0, 1, x_fetch(1));
    add("bad_decode", 0, BADOP, 0, 0, 1, x_decode(1));
    add("bad_refetch", 0, LW, 0, 0, 1, x_fetch(1));
    add("lw2_decode", 0, LW, 0, 0, 1, x_decode(0));
    add("lw2_memadr", 0, LW, 0, 0, 1, X_MEMADR);
    add("lw2_memread_wait", 0, LW, 0, 0, 0, X_MEMREAD);
    add("rst_in_memread", 1, LW, 0, 0, 1, X_ZERO);
    add("after_abort", 0, LW, 0, 0, 0, x_fetch(0));
    add("after_abort_hold", 0, LW, 0, 0, 0, x_fetch(0));

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      rst = tv[i].rst; opcode = tv[i].op; func3 = tv[i].f3; zero = tv[i].z; mem_ready = tv[i].mr;
      @(negedge clk);
      chk(tv[i].name, act, tv[i].exp);
    end

    step_h(1, BADOP, 1, X_ZERO, "h_rst0");
    step_h(1, BADOP, 1, X_ZERO, "h_rst1");
    step_h(0, BADOP, 1, x_fetch(1), "h_fetch");
    step_h(0, BADOP, 1, x_decode(1), "h_decode_illegal");
    for (int k = 0; k < 4; k++) step_h(0, LW, 1, X_HALT, "h_halted");
    step_h(1, LW, 1, X_ZERO, "h_rst_exit");
    step_h(0, LW, 1, x_fetch(1), "h_fetch_after_rst");
    step_h(0, LW, 1, x_decode(0), "h_decode_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
